// File: rtl/axi_burst_write_master.sv
// rtl/axi_burst_write_master.sv - single-outstanding AXI4 INCR burst write initiator
// Optional 4KB-crossing command rejection: define AXI_WRITE_MASTER_4KB_CHECK_EN.
module axi_burst_write_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_DATA_WIDTH-1:0] s_data,
  input  logic [AXI_STRB_WIDTH-1:0] s_strb,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [1:0]                axi_aw_burst,
  output logic [2:0]                axi_aw_size,
  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [7:0]                axi_aw_len,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,
  output logic [1:0]                rsp_resp,
  output logic [AXI_ID_WIDTH-1:0]   rsp_id,
  output logic                      rsp_valid,
  input  logic                      rsp_ready
);

  localparam int SIZE = $clog2(AXI_STRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1));

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state;
  logic [7:0] beat_cnt;
  logic       aw_done;
  logic       w_done;
  logic       beats_left;
  logic       aw_hs;
  logic       w_hs;
  logic       w_last_hs;
  logic       cmd_reject;

`ifdef AXI_WRITE_MASTER_4KB_CHECK_EN
  logic [31:0] burst_end;
  assign burst_end  = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
  assign cmd_reject = burst_end > 32'd4096;
`else
  assign cmd_reject = 1'b0;
`endif

  // cmd_ready is gated by reset so nothing is offered while reset is held
  assign cmd_ready    = (state == ST_IDLE) && !axi_reset;
  assign beats_left   = (state == ST_BURST) && !w_done;
  assign axi_w_valid  = s_valid & beats_left;
  assign s_ready      = axi_w_ready & beats_left;
  assign axi_w_data   = s_data;
  assign axi_w_strb   = s_strb;
  assign axi_w_last   = beats_left && (beat_cnt == axi_aw_len);
  assign axi_aw_burst = 2'b01;
  assign axi_aw_size  = 3'(SIZE);
  assign axi_b_ready  = (state == ST_RESP);
  assign rsp_valid    = (state == ST_DONE);

  assign aw_hs     = axi_aw_valid & axi_aw_ready;
  assign w_hs      = axi_w_valid & axi_w_ready;
  assign w_last_hs = w_hs & axi_w_last;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state        <= ST_IDLE;
      axi_aw_addr  <= '0;
      axi_aw_len   <= '0;
      axi_aw_id    <= '0;
      axi_aw_valid <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      beat_cnt     <= '0;
      rsp_resp     <= '0;
      rsp_id       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_reject) begin
              rsp_resp <= 2'b10;
              rsp_id   <= cmd_id;
              state    <= ST_DONE;
            end else begin
              axi_aw_addr  <= cmd_addr & ADDR_MASK;
              axi_aw_len   <= cmd_len;
              axi_aw_id    <= cmd_id;
              axi_aw_valid <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              beat_cnt     <= '0;
              state        <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (aw_hs) begin
            axi_aw_valid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (w_hs) beat_cnt <= beat_cnt + 8'd1;
          if (w_last_hs) w_done <= 1'b1;
          // AW and the last W beat may complete on the same edge
          if ((aw_done || aw_hs) && (w_done || w_last_hs)) state <= ST_RESP;
        end
        ST_RESP: begin
          if (axi_b_valid) begin
            rsp_id   <= axi_b_id;
            rsp_resp <= (axi_b_id != axi_aw_id) ? 2'b10 : axi_b_resp;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// tb/tb_axi_burst_write_master.sv - table-driven scoreboard bench for axi_burst_write_master
module tb_axi_burst_write_master;

  logic        axi_clk;
  logic        axi_reset;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_id;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] axi_aw_addr;
  logic [1:0]  axi_aw_burst;
  logic [2:0]  axi_aw_size;
  logic [7:0]  axi_aw_id;
  logic [7:0]  axi_aw_len;
  logic        axi_aw_valid;
  logic        axi_aw_ready;
  logic [31:0] axi_w_data;
  logic [3:0]  axi_w_strb;
  logic        axi_w_last;
  logic        axi_w_valid;
  logic        axi_w_ready;
  logic [1:0]  axi_b_resp;
  logic [7:0]  axi_b_id;
  logic        axi_b_valid;
  logic        axi_b_ready;
  logic [1:0]  rsp_resp;
  logic [7:0]  rsp_id;
  logic        rsp_valid;
  logic        rsp_ready;

  axi_burst_write_master dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
    .axi_aw_addr(axi_aw_addr), .axi_aw_burst(axi_aw_burst), .axi_aw_size(axi_aw_size),
    .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_resp(axi_b_resp), .axi_b_id(axi_b_id), .axi_b_valid(axi_b_valid),
    .axi_b_ready(axi_b_ready),
    .rsp_resp(rsp_resp), .rsp_id(rsp_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [1:0]  bresp;
    bit          bid_flip;
    int          aw_delay;
    bit          wr_toggle;
    int          rsp_delay;
    logic [31:0] exp_addr;
    bit          exp_reject;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_id;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [7:0] id;
  } rsp_exp_t;

  vec_t     vecs[8];
  aw_exp_t  aw_q[$];
  w_exp_t   w_q[$];
  rsp_exp_t rsp_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input int idx, input int k);
    return 32'hDEADBEEF + (32'(idx) << 24) + 32'(k) * 32'h0001_0001;
  endfunction

  function automatic logic [3:0] beat_strb(input int k);
    if (k == 0) return 4'hF;
    return (k % 3 == 1) ? 4'h5 : 4'hA;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; s_valid = 0; axi_aw_ready = 0; axi_w_ready = 0;
    axi_b_valid = 0; rsp_ready = 0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [7:0] i);
    bit hs;
    @(posedge axi_clk); #1;
    cmd_addr = a; cmd_len = l; cmd_id = i; cmd_valid = 1;
    hs = 0;
    for (int t = 0; t < 20 && !hs; t++) begin
      @(negedge axi_clk);
      if (cmd_ready) hs = 1;
      @(posedge axi_clk); #1;
    end
    chk("cmd_accept", 64'(hs), 64'd1);
    cmd_valid = 0;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int k, cyc, rsp_wait;
    bit aw_hs, w_fin, b_pend, b_done, got_rsp;
    if (!v.exp_reject) begin
      aw_q.push_back('{v.exp_addr, v.len, v.id});
      for (int b = 0; b <= int'(v.len); b++)
        w_q.push_back('{beat_data(idx, b), beat_strb(b), b == int'(v.len)});
    end
    rsp_q.push_back('{v.exp_resp, v.exp_id});
    send_cmd(v.addr, v.len, v.id);
    k = 0; cyc = 0; rsp_wait = 0;
    aw_hs = 0; w_fin = 0; b_pend = 0; b_done = 0; got_rsp = 0;
    while (!got_rsp && cyc < 3000) begin
      s_valid      = (k <= int'(v.len));
      s_data       = beat_data(idx, k);
      s_strb       = beat_strb(k);
      axi_aw_ready = (cyc >= v.aw_delay);
      axi_w_ready  = v.wr_toggle ? (cyc % 2 == 0) : 1'b1;
      axi_b_valid  = b_pend;
      axi_b_resp   = v.bresp;
      axi_b_id     = v.bid_flip ? (v.id ^ 8'h01) : v.id;
      rsp_ready    = (rsp_wait >= v.rsp_delay);
      @(negedge axi_clk);
      if (v.exp_reject) begin
        chk("reject_no_aw", 64'(axi_aw_valid), 64'd0);
        chk("reject_no_s_ready", 64'(s_ready), 64'd0);
      end else if (cyc == 0) begin
        chk("aw_latency", 64'(axi_aw_valid), 64'd1);
      end
      if (!aw_hs) chk("no_resp_before_aw", 64'(axi_b_ready), 64'd0);
      if (v.wr_toggle && k <= int'(v.len) && !v.exp_reject)
        chk("s_ready_mirror", 64'(s_ready), 64'(axi_w_ready));
      if (axi_aw_valid && aw_q.size() > 0) begin
        chk("aw_fields", {axi_aw_addr, axi_aw_len, axi_aw_id}, aw_q[0]);
        chk("aw_size_burst", {axi_aw_burst, axi_aw_size}, {2'b01, 3'd2});
        if (axi_aw_ready) begin
          void'(aw_q.pop_front());
          aw_hs = 1;
        end
      end
      if (axi_w_valid && axi_w_ready) begin
        chk("w_beat_expected", 64'(w_q.size() > 0), 64'd1);
        if (w_q.size() > 0) begin
          chk("w_beat", {axi_w_data, axi_w_strb, axi_w_last}, w_q.pop_front());
          if (k == int'(v.len)) w_fin = 1;
        end
        k++;
      end
      if (axi_b_valid && axi_b_ready) begin
        b_pend = 0;
        b_done = 1;
      end
      if (aw_hs && w_fin && !b_done) b_pend = 1;
      if (rsp_valid) begin
        if (v.exp_reject) chk("reject_latency", 64'(cyc < 2), 64'd1);
        if (rsp_ready) begin
          if (rsp_q.size() > 0) chk("rsp", {rsp_resp, rsp_id}, rsp_q.pop_front());
          got_rsp = 1;
        end else begin
          rsp_wait++;
        end
      end
      @(posedge axi_clk); #1;
      cyc++;
    end
    idle_inputs();
    chk("txn_complete", 64'(got_rsp), 64'd1);
    chk("aw_q_empty", 64'(aw_q.size()), 64'd0);
    chk("w_q_empty", 64'(w_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    aw_q.delete(); w_q.delete(); rsp_q.delete();
  endtask

  initial begin
    int k;
    // addr, len, id, bresp, flip, aw_dly, toggle, rsp_dly, exp_addr, reject, exp_resp, exp_id
    vecs[0] = '{32'h0000_0100, 8'd0,   8'h03, 2'b00, 1'b0, 0,  1'b0, 0, 32'h0000_0100, 1'b0, 2'b00, 8'h03};
    vecs[1] = '{32'h0000_2000, 8'd15,  8'h11, 2'b00, 1'b0, 0,  1'b1, 0, 32'h0000_2000, 1'b0, 2'b00, 8'h11};
    vecs[2] = '{32'h0000_3000, 8'd3,   8'h22, 2'b00, 1'b0, 20, 1'b0, 0, 32'h0000_3000, 1'b0, 2'b00, 8'h22};
    vecs[3] = '{32'h0000_4000, 8'd1,   8'h33, 2'b10, 1'b0, 0,  1'b0, 0, 32'h0000_4000, 1'b0, 2'b10, 8'h33};
    vecs[4] = '{32'h0000_5000, 8'd2,   8'h44, 2'b00, 1'b1, 0,  1'b0, 0, 32'h0000_5000, 1'b0, 2'b10, 8'h45};
    vecs[5] = '{32'h0000_6003, 8'd2,   8'h55, 2'b00, 1'b0, 1,  1'b0, 3, 32'h0000_6000, 1'b0, 2'b00, 8'h55};
`ifdef AXI_WRITE_MASTER_4KB_CHECK_EN
    vecs[6] = '{32'h0000_0FF8, 8'd3,   8'h66, 2'b00, 1'b0, 0,  1'b0, 0, 32'h0000_0000, 1'b1, 2'b10, 8'h66};
`else
    vecs[6] = '{32'h0000_0FF8, 8'd3,   8'h66, 2'b00, 1'b0, 0,  1'b0, 0, 32'h0000_0FF8, 1'b0, 2'b00, 8'h66};
`endif
    vecs[7] = '{32'h0000_0C00, 8'd255, 8'h77, 2'b00, 1'b0, 5,  1'b0, 0, 32'h0000_0C00, 1'b0, 2'b00, 8'h77};

    axi_reset = 1;
    cmd_addr = 0; cmd_len = 0; cmd_id = 0; s_data = 0; s_strb = 0;
    axi_b_resp = 0; axi_b_id = 0;
    idle_inputs();
    #2;
    chk("reset_outputs_low",
        {cmd_ready, s_ready, axi_aw_valid, axi_w_valid, axi_b_ready, rsp_valid}, 6'b0);
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 0;
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_regs", {axi_aw_addr, axi_aw_len, axi_aw_id, rsp_resp, rsp_id}, 58'd0);

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Reset asserted while beat 5 of an 8-beat burst is on the bus
    send_cmd(32'h0000_8000, 8'd7, 8'h5A);
    axi_aw_ready = 1; axi_w_ready = 1;
    k = 0;
    for (int t = 0; t < 40 && k < 4; t++) begin
      s_valid = 1; s_data = beat_data(9, k); s_strb = 4'hF;
      @(negedge axi_clk);
      if (axi_w_valid && axi_w_ready) k++;
      @(posedge axi_clk); #1;
    end
    s_valid = 1; s_data = beat_data(9, k);
    #1;
    chk("t5_beat5_live", {axi_w_valid, axi_w_last}, 2'b10);
    #1;
    axi_reset = 1;
    #1;
    chk("t5_async_drop",
        {cmd_ready, s_ready, axi_aw_valid, axi_w_valid, axi_b_ready, rsp_valid}, 6'b0);
    @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 0; s_valid = 0;
    #1;
    chk("t5_cmd_ready_after_release", 64'(cmd_ready), 64'd1);
    axi_b_valid = 1; axi_b_id = 8'h5A; axi_b_resp = 2'b00; rsp_ready = 1;
    for (int t = 0; t < 6; t++) begin
      @(negedge axi_clk);
      chk("t5_quiet", {rsp_valid, axi_w_valid, axi_w_last, axi_b_ready}, 4'b0);
    end
    idle_inputs();

    run_txn(8, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
